// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the SRAM debug UART command protocol.
// Command/response byte values, request opcodes and completion codes.
package uart_cmd_pkg;

   localparam logic [7:0] CMD_HB_TOGGLE = 8'h01;
   localparam logic [7:0] CMD_WRITE     = 8'h02;
   localparam logic [7:0] CMD_READ      = 8'h03;
   localparam logic [7:0] CMD_PING      = 8'h04;

   localparam logic [7:0] RSP_HB     = 8'hAA;
   localparam logic [7:0] RSP_WR_ACK = 8'hAC;
   localparam logic [7:0] RSP_PONG   = 8'hEE;

   localparam int FRAME_MAX = 5;

   typedef enum logic [1:0] {
      OP_HB_TOGGLE = 2'd0,
      OP_WRITE     = 2'd1,
      OP_READ      = 2'd2,
      OP_PING      = 2'd3
   } req_op_e;

   typedef enum logic [1:0] {
      ST_OK       = 2'd0,
      ST_TIMEOUT  = 2'd1,
      ST_BAD_BYTE = 2'd2
   } rsp_status_e;

   function automatic logic [7:0] cmd_byte(input req_op_e op);
      logic [7:0] b;
      unique case (op)
         OP_HB_TOGGLE: b = CMD_HB_TOGGLE;
         OP_WRITE:     b = CMD_WRITE;
         OP_READ:      b = CMD_READ;
         default:      b = CMD_PING;
      endcase
      return b;
   endfunction

   // Index of the final byte in the frame for each opcode.
   function automatic logic [2:0] frame_last(input req_op_e op);
      logic [2:0] n;
      unique case (op)
         OP_WRITE: n = 3'd4;
         OP_READ:  n = 3'd2;
         default:  n = 3'd0;
      endcase
      return n;
   endfunction

   function automatic logic [7:0] ack_byte(input req_op_e op);
      return (op == OP_WRITE) ? RSP_WR_ACK : RSP_PONG;
   endfunction

endpackage

// File: rtl/uart_sram_cmd_master.sv
// Host-side SRAM debug UART initiator: serializes one request into
// command bytes, then parses the reply into a single completion.
module uart_sram_cmd_master
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   output logic [1:0]  rsp_status,
   output logic [15:0] rsp_rdata,
   output logic        hb_seen,
   output logic [7:0]  tx_data,
   output logic        tx_send,
   input  logic        tx_busy,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_DRAIN,
      S_RESP,
      S_DONE
   } state_e;

   localparam logic [31:0] TIMER_TERM = 32'(TIMEOUT_CYCLES - 1);
   localparam logic [31:0] TIMER_MAX  = '1;

   state_e      state_q;
   state_e      state_d;
   req_op_e     op_q;
   logic [7:0]  frame_q [FRAME_MAX];
   logic [2:0]  idx_q;
   logic [2:0]  last_q;
   logic        guard_q;
   logic [31:0] timer_q;
   logic [7:0]  rd_hi_q;
   logic        rd_have_q;
   logic [1:0]  status_q;
   logic [15:0] rdata_q;
   logic        hb_q;

   logic        accept;
   logic        send_go;
   logic        rx_hb;
   logic        done;
   logic [1:0]  done_status;
   logic [15:0] done_rdata;
   logic        timer_clr;
   logic        timer_inc;
   logic        take_hi;
   logic        hb_d;

   assign accept  = req_valid && (state_q == S_IDLE);
   assign send_go = (state_q == S_SEND) && !guard_q && !tx_busy;
   assign rx_hb   = rx_valid && (rx_data == RSP_HB);

   assign req_ready  = (state_q == S_IDLE);
   assign tx_send    = send_go;
   assign tx_data    = send_go ? frame_q[idx_q] : 8'h00;
   assign rsp_valid  = (state_q == S_DONE);
   assign rsp_status = status_q;
   assign rsp_rdata  = rdata_q;
   assign hb_seen    = hb_q;

   always_comb begin
      state_d     = state_q;
      done        = 1'b0;
      done_status = ST_OK;
      done_rdata  = '0;
      timer_clr   = 1'b0;
      timer_inc   = 1'b0;
      take_hi     = 1'b0;
      // Heartbeats are filtered everywhere except while parsing a reply.
      hb_d        = rx_hb && (state_q != S_RESP);
      unique case (state_q)
         S_IDLE: begin
            if (req_valid) state_d = S_SEND;
         end
         S_SEND: begin
            if (send_go && idx_q == last_q) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (!guard_q && !tx_busy) begin
               if (op_q == OP_HB_TOGGLE) begin
                  done    = 1'b1;
                  state_d = S_DONE;
               end else begin
                  timer_clr = 1'b1;
                  state_d   = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (rx_valid) begin
               timer_clr = 1'b1;
               if (op_q == OP_READ) begin
                  if (rd_have_q) begin
                     done       = 1'b1;
                     done_rdata = {rd_hi_q, rx_data};
                     state_d    = S_DONE;
                  end else begin
                     take_hi = 1'b1;
                  end
               end else begin
                  unique case (1'b1)
                     (rx_data == ack_byte(op_q)): begin
                        done    = 1'b1;
                        state_d = S_DONE;
                     end
                     rx_hb: hb_d = 1'b1;
                     default: begin
                        done        = 1'b1;
                        done_status = ST_BAD_BYTE;
                        state_d     = S_DONE;
                     end
                  endcase
               end
            end else if (timer_q == TIMER_TERM) begin
               done        = 1'b1;
               done_status = ST_TIMEOUT;
               state_d     = S_DONE;
            end else begin
               timer_inc = 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         op_q      <= OP_HB_TOGGLE;
         for (int i = 0; i < FRAME_MAX; i++) frame_q[i] <= '0;
         idx_q     <= '0;
         last_q    <= '0;
         guard_q   <= 1'b0;
         timer_q   <= '0;
         rd_hi_q   <= '0;
         rd_have_q <= 1'b0;
         status_q  <= ST_OK;
         rdata_q   <= '0;
         hb_q      <= 1'b0;
      end else begin
         state_q <= state_d;
         hb_q    <= hb_d;
         // Covers the cycle before tx_busy rises after a send.
         guard_q <= send_go;
         if (accept) begin
            op_q       <= req_op_e'(req_op);
            frame_q[0] <= cmd_byte(req_op_e'(req_op));
            frame_q[1] <= req_addr[15:8];
            frame_q[2] <= req_addr[7:0];
            frame_q[3] <= req_wdata[15:8];
            frame_q[4] <= req_wdata[7:0];
            idx_q      <= '0;
            last_q     <= frame_last(req_op_e'(req_op));
            rd_have_q  <= 1'b0;
         end else if (send_go) begin
            idx_q <= idx_q + 3'd1;
         end
         if (timer_clr) begin
            timer_q <= '0;
         end else if (timer_inc && timer_q != TIMER_MAX) begin
            timer_q <= timer_q + 32'd1;
         end
         if (take_hi) begin
            rd_hi_q   <= rx_data;
            rd_have_q <= 1'b1;
         end
         if (done) begin
            status_q  <= done_status;
            rdata_q   <= done_rdata;
            rd_have_q <= 1'b0;
         end
      end
   end

endmodule
